mipse_mc: RTL and testbench
===========================

Name: mipse_mc

Overview:
- Multi-cycle successor to the single-cycle MIPS-subset core; same instruction subset, now parametrised.
- Executes from one unified memory port with a req/ack handshake, so the core tolerates arbitrary memory wait states.
- Contains its own 32x32 register file; $0 is hardwired to zero.
- Adds a retired-instruction counter and a halt state. Sits between the top-level test harness and a single-port memory model.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- HALT_INSTR, 32'h1000_ffff, instruction word that enters HALT.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- mem_req  out  1  memory request valid
- mem_we  out  4  byte write enables; bit3 = addr[1:0]==0 (big-endian lanes); 0000 = read
- mem_addr  out  32  byte address
- mem_wdata  out  32  write data, lane-aligned
- mem_rdata  in  32  read data, valid when mem_ack=1
- mem_ack  in  1  completes the request this cycle
- pc  out  32  current PC
- finish  out  1  high in HALT
- instret  out  CNT_W  retired-instruction count

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk.
  - Reset values: state=FETCH, pc=RESET_PC, instret=0, mem_req=0, mem_we=0, finish=0.
  - Register file contents are not reset.
  - Reset mid-transaction drops mem_req immediately; no write completes.
- Handshake:
  - mem_addr, mem_we and mem_wdata are held stable while mem_req=1.
  - A transfer completes on a clk edge with mem_req=1 and mem_ack=1. Zero-wait ack (same cycle) is legal.
  - mem_ack without mem_req is ignored.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH:
  - mem_req=1, mem_addr=pc, mem_we=0.
  - On ack: IR<=mem_rdata, pc<=pc+4, go to DECODE.
- DECODE:
  - If IR==HALT_INSTR, go to HALT (not retired). Otherwise latch A=R[rs], B=R[rt] and go to EXEC.
- EXEC: ALU operates on A and the operand selected by opcode.
  - Immediates: sign-extended for addi, lw, sw, lb, sb; zero-extended for andi, ori; lui yields imm<<16.
  - R-type funcs: add 100000, sub 100010, and 100100, or 100101. slt 101010 is signed and yields 0 or 1.
  - beq 000100 / bne 000101: if taken, pc<=pc+(signimm<<2), using the already-incremented pc. Retire, go to FETCH.
  - j 000010: pc<={pc[31:28],IR[25:0],2'b00}. Retire, go to FETCH.
  - jal 000011: same target as j; link<=old pc (pc+4 of the jal); go to WB with rd=31.
  - jr (R-type, func 001000): pc<=A. Retire, go to FETCH.
  - lw 100011, lb 100000, sw 101011, sb 101000: go to MEM.
  - All other ALU ops go to WB.
  - Unrecognised opcode or func: NOP; retire, go to FETCH.
- MEM: mem_req=1, mem_addr=ALU result (no alignment check on lw/sw; addr[1:0] passed through).
  - sw: mem_we=1111, wdata=B.
  - sb: one-hot lane from addr[1:0] (00->1000, 01->0100, 10->0010, 11->0001); B[7:0] replicated into all lanes.
  - On ack: a store retires and goes to FETCH; a load captures data and goes to WB.
  - lb selects the lane big-endian (00 -> rdata[31:24]) and sign-extends it.
- WB: write R[dest] (rd for R-type, 31 for jal, rt otherwise); writes to $0 are discarded. Retire, go to FETCH.
- Retire means instret<=instret+1, wrapping modulo 2^CNT_W.
- HALT: absorbing until reset. finish=1, pc is frozen, mem_req=0.
- Cycle counts with zero-wait memory: ALU/imm 4, lw/lb 5, sw/sb 4, branch/j/jr 3, jal 4.
  - Every memory wait cycle adds 1.
- Register file reads are combinational. A write in WB is visible to the next DECODE.

Test Plan:
- Reset, mem ack zero-wait, program `addi $1,$0,5; addi $2,$1,-7; slt $3,$2,$1; HALT` -> $1=5, $2=0xFFFFFFFE, $3=1; finish=1 at pc=16; instret=3; total 4+4+4+2 cycles.
- `lui $1,0x1234; ori $1,$1,0xABCD; sb $1,3($0); lb $2,3($0)` -> sb issues mem_we=0001, wdata low byte 0xCD; $2=0xFFFFFFCD.
- Random 0–5 cycle ack delays on every request -> results identical to zero-wait run; mem_addr/we/wdata never change while mem_req=1.
- `beq $0,$0,+2` at pc=0x20 -> next fetch address 0x2C. `jal 0x40` at 0x30 -> pc=0x100, $31=0x34. `jr $31` -> pc=0x34.
- `addi $0,$0,9` then `add $4,$0,$0` -> $4=0. Unknown opcode 6'b111111 -> instret increments, no register or memory write.
- Assert rst_n low while mem_req=1 in MEM for an sw (ack held low) -> mem_req=0 immediately; pc=RESET_PC; no write observed; instret=0.

Source files
------------

// File: rtl/mipse_mc.sv
// Multi-cycle MIPS-subset core with a unified req/ack memory port, an internal 32x32
// register file, a retired-instruction counter and an absorbing HALT state.
module mipse_mc #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] HALT_INSTR = 32'h1000_ffff,
    parameter int          CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             mem_req,
    output logic [3:0]       mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_ack,
    output logic [31:0]      pc,
    output logic             finish,
    output logic [CNT_W-1:0] instret,
    output logic [2:0]       dbg_state
);

    // Handshake: mem_req is the valid, mem_ack the ready. A transfer completes on the
    // clk edge where both are high; addr/we/wdata stay fixed while mem_req is high and
    // mem_ack without mem_req has no effect.

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        C_NOP, C_ALU, C_MEM, C_BR, C_J, C_JAL, C_JR
    } cls_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    state_t           r_state;
    state_t           w_next;
    logic [31:0]      r_pc;
    logic [31:0]      r_ir;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic [31:0]      r_res;
    logic [CNT_W-1:0] r_instret;
    logic [31:0]      r_rf [32];

    logic [5:0]  w_op;
    logic [5:0]  w_fn;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [4:0]  w_dest;
    logic [31:0] w_simm;
    logic [31:0] w_zimm;
    logic [31:0] w_rf_a;
    logic [31:0] w_rf_b;
    logic [31:0] w_alu;
    logic [31:0] w_btarget;
    logic [31:0] w_jtarget;
    logic [31:0] w_load;
    logic [7:0]  w_lbyte;
    logic [3:0]  w_lane;
    logic        w_taken;
    logic        w_store;
    logic        w_byte;
    cls_t        w_cls;

    logic        w_req;
    logic [3:0]  w_we;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic        w_retire;

    assign w_op   = r_ir[31:26];
    assign w_rs   = r_ir[25:21];
    assign w_rt   = r_ir[20:16];
    assign w_rd   = r_ir[15:11];
    assign w_fn   = r_ir[5:0];
    assign w_simm = {{16{r_ir[15]}}, r_ir[15:0]};
    assign w_zimm = {16'h0000, r_ir[15:0]};

    assign w_rf_a = (w_rs == 5'd0) ? 32'h0 : r_rf[w_rs];
    assign w_rf_b = (w_rt == 5'd0) ? 32'h0 : r_rf[w_rt];
    assign w_dest = (w_op == OP_RTYPE) ? w_rd : ((w_op == OP_JAL) ? 5'd31 : w_rt);

    assign w_store   = (w_op == OP_SW) || (w_op == OP_SB);
    assign w_byte    = (w_op == OP_SB) || (w_op == OP_LB);
    assign w_taken   = (w_op == OP_BEQ) ? (r_a == r_b) : (r_a != r_b);
    // Branch and jump targets are relative to the pc already advanced in FETCH.
    assign w_btarget = r_pc + {w_simm[29:0], 2'b00};
    assign w_jtarget = {r_pc[31:28], r_ir[25:0], 2'b00};

    always_comb begin
        w_cls = C_NOP;
        w_alu = 32'h0;
        case (w_op)
            OP_RTYPE: begin
                case (w_fn)
                    FN_ADD:  begin w_cls = C_ALU; w_alu = r_a + r_b; end
                    FN_SUB:  begin w_cls = C_ALU; w_alu = r_a - r_b; end
                    FN_AND:  begin w_cls = C_ALU; w_alu = r_a & r_b; end
                    FN_OR:   begin w_cls = C_ALU; w_alu = r_a | r_b; end
                    FN_SLT:  begin w_cls = C_ALU; w_alu = {31'h0, $signed(r_a) < $signed(r_b)}; end
                    FN_JR:   w_cls = C_JR;
                    default: w_cls = C_NOP;
                endcase
            end
            OP_ADDI: begin w_cls = C_ALU; w_alu = r_a + w_simm; end
            OP_ANDI: begin w_cls = C_ALU; w_alu = r_a & w_zimm; end
            OP_ORI:  begin w_cls = C_ALU; w_alu = r_a | w_zimm; end
            OP_LUI:  begin w_cls = C_ALU; w_alu = {r_ir[15:0], 16'h0000}; end
            OP_LW, OP_LB, OP_SW, OP_SB: begin w_cls = C_MEM; w_alu = r_a + w_simm; end
            OP_BEQ, OP_BNE: w_cls = C_BR;
            OP_J:    w_cls = C_J;
            OP_JAL:  begin w_cls = C_JAL; w_alu = r_pc; end
            default: w_cls = C_NOP;
        endcase
    end

    // Big-endian byte lanes: address offset 0 is the most significant byte.
    always_comb begin
        w_lane  = 4'b1000;
        w_lbyte = mem_rdata[31:24];
        case (r_res[1:0])
            2'b00: begin w_lane = 4'b1000; w_lbyte = mem_rdata[31:24]; end
            2'b01: begin w_lane = 4'b0100; w_lbyte = mem_rdata[23:16]; end
            2'b10: begin w_lane = 4'b0010; w_lbyte = mem_rdata[15:8];  end
            default: begin w_lane = 4'b0001; w_lbyte = mem_rdata[7:0]; end
        endcase
        w_load = w_byte ? {{24{w_lbyte[7]}}, w_lbyte} : mem_rdata;
    end

    always_comb begin
        w_next   = r_state;
        w_req    = 1'b0;
        w_we     = 4'b0000;
        w_addr   = r_pc;
        w_wdata  = r_b;
        w_retire = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_req = 1'b1;
                if (mem_ack) w_next = S_DECODE;
            end
            S_DECODE: w_next = (r_ir == HALT_INSTR) ? S_HALT : S_EXEC;
            S_EXEC: begin
                case (w_cls)
                    C_ALU, C_JAL: w_next = S_WB;
                    C_MEM:        w_next = S_MEM;
                    default: begin
                        w_next   = S_FETCH;
                        w_retire = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                w_req  = 1'b1;
                w_addr = r_res;
                if (w_store) begin
                    w_we    = w_byte ? w_lane : 4'b1111;
                    w_wdata = w_byte ? {4{r_b[7:0]}} : r_b;
                end
                if (mem_ack) begin
                    w_next   = w_store ? S_FETCH : S_WB;
                    w_retire = w_store;
                end
            end
            S_WB: begin
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            default: w_next = S_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_FETCH;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc      <= RESET_PC;
            r_ir      <= 32'h0;
            r_a       <= 32'h0;
            r_b       <= 32'h0;
            r_res     <= 32'h0;
            r_instret <= '0;
        end else begin
            if (w_retire) r_instret <= r_instret + CNT_W'(1);
            case (r_state)
                S_FETCH: begin
                    if (mem_ack) begin
                        r_ir <= mem_rdata;
                        r_pc <= r_pc + 32'd4;
                    end
                end
                S_DECODE: begin
                    r_a <= w_rf_a;
                    r_b <= w_rf_b;
                end
                S_EXEC: begin
                    r_res <= w_alu;
                    case (w_cls)
                        C_BR:      if (w_taken) r_pc <= w_btarget;
                        C_J, C_JAL: r_pc <= w_jtarget;
                        C_JR:      r_pc <= r_a;
                        default:   r_pc <= r_pc;
                    endcase
                end
                S_MEM: begin
                    if (mem_ack && !w_store) r_res <= w_load;
                end
                default: r_res <= r_res;
            endcase
        end
    end

    // Register file is deliberately not reset; $0 is forced to zero on the read side.
    always_ff @(posedge clk) begin
        if (r_state == S_WB && w_dest != 5'd0) r_rf[w_dest] <= r_res;
    end

    // Gating with rst_n drops the request the moment reset asserts mid-transfer.
    assign mem_req   = w_req & rst_n;
    assign mem_we    = w_we;
    assign mem_addr  = w_addr;
    assign mem_wdata = w_wdata;
    assign pc        = r_pc;
    assign finish    = (r_state == S_HALT);
    assign instret   = r_instret;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_mipse_mc.sv
// Bench for mipse_mc: ISA-level reference model, 1 KB memory with random ack delays,
// transaction scoreboard and directed/random programs.
module tb_mipse_mc;

    localparam logic [31:0] HALT = 32'h1000_ffff;
    localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_JAL = 6'b000011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100, OP_ORI = 6'b001101, OP_LUI = 6'b001111;
    localparam logic [5:0] OP_LB = 6'b100000, OP_LW = 6'b100011, OP_SB = 6'b101000;
    localparam logic [5:0] OP_SW = 6'b101011;
    localparam logic [5:0] FN_ADD = 6'b100000, FN_SUB = 6'b100010, FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR = 6'b100101, FN_SLT = 6'b101010, FN_JR = 6'b001000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_req;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [31:0] pc;
    logic        finish;
    logic [31:0] instret;
    logic [2:0]  dbg_state;

    mipse_mc dut (
        .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .pc(pc), .finish(finish), .instret(instret),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [67:0] got, input logic [67:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [31:0] img   [256];
    logic [31:0] mem   [256];
    logic [31:0] m_mem [256];
    logic [31:0] m_r   [32];
    logic [67:0] exp_q [$];
    logic [35:0] wr_log [$];
    logic [31:0] rd_log [$];
    logic [31:0] pp;

    int          max_delay = 0;
    int          d_left = 0;
    bit          in_req = 0;
    bit          stall_writes = 0;
    bit          sb_on = 1;
    logic [67:0] cur_txn;
    int          waits = 0;
    int          hold_err = 0;
    int          extra = 0;
    int          n_writes = 0;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] we,
                                          input logic [31:0] wd);
        logic [31:0] o;
        o = old;
        for (int i = 0; i < 4; i++) if (we[i]) o[8*i +: 8] = wd[8*i +: 8];
        return o;
    endfunction

    function automatic logic [31:0] ei(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] er(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [5:0] fn);
        return {OP_R, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] ej(input logic [5:0] op, input logic [25:0] idx);
        return {op, idx};
    endfunction

    task automatic put(input logic [31:0] w);
        img[pp[9:2]] = w;
        pp = pp + 32'd4;
    endtask

    task automatic clear_img();
        for (int i = 0; i < 256; i++) img[i] = 32'h0;
        pp = 32'h0;
    endtask

    // Memory responder: a new request gets a random delay; fields are sampled away
    // from the active edge and compared every pending cycle.
    always @(negedge clk) begin
        if (!rst_n || !mem_req) begin
            mem_ack = 1'b0;
            in_req  = 1'b0;
        end else begin
            if (!in_req) begin
                in_req  = 1'b1;
                d_left  = $urandom_range(max_delay, 0);
                cur_txn = {mem_we, mem_addr, (mem_we != 4'b0) ? mem_wdata : 32'h0};
            end else if ({mem_we, mem_addr, (mem_we != 4'b0) ? mem_wdata : 32'h0} !== cur_txn) begin
                hold_err++;
            end
            mem_rdata = mem[mem_addr[9:2]];
            if ((stall_writes && mem_we != 4'b0) || d_left > 0) begin
                mem_ack = 1'b0;
                waits++;
                if (d_left > 0) d_left--;
            end else begin
                mem_ack = 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        if (mem_ack && in_req) begin
            in_req = 1'b0;
            if (sb_on) begin
                if (exp_q.size() > 0) check("txn", cur_txn, exp_q.pop_front());
                else extra++;
            end
            if (cur_txn[67:64] != 4'b0) begin
                n_writes++;
                wr_log.push_back({cur_txn[67:64], cur_txn[31:0]});
                mem[cur_txn[41:34]] = merge(mem[cur_txn[41:34]], cur_txn[67:64], cur_txn[31:0]);
            end else begin
                rd_log.push_back(cur_txn[63:32]);
            end
        end
    end

    // Instruction-set level model: executes the image, records every expected memory
    // transaction and the cycle count implied by each instruction class.
    task automatic model_run(output logic [31:0] e_pc, output int e_ret, output int e_cyc);
        logic [31:0] p, ir, a, b, simm, addr, res, wd;
        logic [7:0]  by;
        logic [3:0]  we;
        logic [4:0]  dst;
        bit          wr, ld, st, halted;
        p = 32'h0; e_ret = 0; e_cyc = 0; halted = 0;
        exp_q.delete();
        for (int i = 0; i < 32; i++) m_r[i] = 32'h0;
        for (int step = 0; step < 2000 && !halted; step++) begin
            ir = m_mem[p[9:2]];
            exp_q.push_back({4'h0, p, 32'h0});
            p = p + 4;
            e_cyc += 2;
            if (ir == HALT) begin
                halted = 1;
            end else begin
                a = m_r[ir[25:21]]; b = m_r[ir[20:16]];
                simm = {{16{ir[15]}}, ir[15:0]};
                wr = 0; ld = 0; st = 0; dst = ir[20:16]; res = 0;
                e_ret++;
                case (ir[31:26])
                    OP_R: begin
                        dst = ir[15:11];
                        case (ir[5:0])
                            FN_ADD: begin res = a + b; wr = 1; end
                            FN_SUB: begin res = a - b; wr = 1; end
                            FN_AND: begin res = a & b; wr = 1; end
                            FN_OR:  begin res = a | b; wr = 1; end
                            FN_SLT: begin res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; wr = 1; end
                            FN_JR:  p = a;
                            default: ;
                        endcase
                    end
                    OP_ADDI: begin res = a + simm; wr = 1; end
                    OP_ANDI: begin res = a & {16'h0, ir[15:0]}; wr = 1; end
                    OP_ORI:  begin res = a | {16'h0, ir[15:0]}; wr = 1; end
                    OP_LUI:  begin res = {ir[15:0], 16'h0}; wr = 1; end
                    OP_BEQ:  if (a == b) p = p + (simm << 2);
                    OP_BNE:  if (a != b) p = p + (simm << 2);
                    OP_J:    p = {p[31:28], ir[25:0], 2'b00};
                    OP_JAL:  begin res = p; dst = 5'd31; wr = 1; p = {p[31:28], ir[25:0], 2'b00}; end
                    OP_LW, OP_LB: begin
                        addr = a + simm; ld = 1; wr = 1;
                        exp_q.push_back({4'h0, addr, 32'h0});
                        res = m_mem[addr[9:2]];
                        if (ir[31:26] == OP_LB) begin
                            by  = 8'(res >> (8 * (3 - addr[1:0])));
                            res = {{24{by[7]}}, by};
                        end
                    end
                    OP_SW, OP_SB: begin
                        addr = a + simm; st = 1;
                        if (ir[31:26] == OP_SW) begin we = 4'b1111; wd = b; end
                        else begin we = 4'b1000 >> addr[1:0]; wd = {4{b[7:0]}}; end
                        exp_q.push_back({we, addr, wd});
                        m_mem[addr[9:2]] = merge(m_mem[addr[9:2]], we, wd);
                    end
                    default: ;
                endcase
                if (wr && dst != 5'd0) m_r[dst] = res;
                e_cyc += ld ? 3 : ((wr || st) ? 2 : 1);
            end
        end
        e_pc = p;
    endtask

    task automatic run_dut(input int budget, output int cyc);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        cyc = 0;
        while (cyc < budget) begin
            @(posedge clk);
            cyc++;
            #1;
            if (finish) break;
        end
    endtask

    task automatic run_test(input string name, input int maxd, output int cyc);
        logic [31:0] e_pc;
        int          e_ret, e_cyc, diffs;
        mem = img;
        m_mem = img;
        model_run(e_pc, e_ret, e_cyc);
        max_delay = maxd;
        waits = 0; hold_err = 0; extra = 0; n_writes = 0;
        wr_log.delete(); rd_log.delete();
        run_dut(4000, cyc);
        check({name, "_finish"}, finish, 1);
        check({name, "_pc"}, pc, e_pc);
        check({name, "_instret"}, instret, e_ret);
        check({name, "_cycles"}, cyc, e_cyc + waits);
        check({name, "_txn_left"}, exp_q.size(), 0);
        check({name, "_txn_extra"}, extra, 0);
        check({name, "_hold"}, hold_err, 0);
        diffs = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== m_mem[i]) diffs++;
        check({name, "_mem_image"}, diffs, 0);
    endtask

    task automatic gen_random();
        logic [4:0] r1, r2, r3;
        logic [15:0] imm;
        clear_img();
        for (int i = 128; i < 192; i++) img[i] = $urandom;
        for (int r = 1; r < 8; r++) begin
            put(ei(OP_LUI, 5'd0, 5'(r), 16'($urandom_range(16'hffff, 0))));
            put(ei(OP_ORI, 5'(r), 5'(r), 16'($urandom_range(16'hffff, 0))));
        end
        for (int k = 0; k < 24; k++) begin
            r1 = 5'($urandom_range(7, 0)); r2 = 5'($urandom_range(7, 0));
            r3 = 5'($urandom_range(7, 0));
            imm = 16'($urandom_range(16'hffff, 0));
            case ($urandom_range(11, 0))
                0: put(er(r1, r2, r3, FN_ADD));
                1: put(er(r1, r2, r3, FN_SUB));
                2: put(er(r1, r2, r3, FN_AND));
                3: put(er(r1, r2, r3, FN_OR));
                4: put(er(r1, r2, r3, FN_SLT));
                5: put(ei(OP_ADDI, r1, r2, imm));
                6: put(ei(OP_ANDI, r1, r2, imm));
                7: put(ei(OP_ORI, r1, r2, imm));
                8: put(ei(OP_SW, 5'd0, r2, 16'(16'h200 + 4 * $urandom_range(63, 0))));
                9: put(ei(OP_SB, 5'd0, r2, 16'(16'h200 + $urandom_range(255, 0))));
                10: put(ei(($urandom_range(1, 0) != 0) ? OP_LW : OP_LB, 5'd0, r2,
                          16'(16'h200 + $urandom_range(255, 0))));
                default: put({6'b111111, 26'($urandom)});
            endcase
        end
        for (int r = 1; r < 8; r++) put(ei(OP_SW, 5'd0, 5'(r), 16'(16'h300 + 4 * r)));
        put(HALT);
    endtask

    initial begin
        int cyc;
        int k;
        logic [31:0] nxt;
        rst_n = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
        #1;
        check("reset_req", mem_req, 0);
        check("reset_we", mem_we, 0);
        check("reset_pc", pc, 32'h0);
        check("reset_instret", instret, 0);
        check("reset_finish", finish, 0);

        // addi/addi/slt then HALT: 4+4+4+2 cycles
        clear_img();
        put(ei(OP_ADDI, 5'd0, 5'd1, 16'd5));
        put(ei(OP_ADDI, 5'd1, 5'd2, 16'hfff9));
        put(er(5'd2, 5'd1, 5'd3, FN_SLT));
        put(HALT);
        run_test("t1", 0, cyc);
        check("t1_cycles_abs", cyc, 14);
        check("t1_pc_abs", pc, 32'd16);
        check("t1_instret_abs", instret, 3);

        // same results made visible through stores
        pp = 32'hc;
        put(ei(OP_SW, 5'd0, 5'd1, 16'h200));
        put(ei(OP_SW, 5'd0, 5'd2, 16'h204));
        put(ei(OP_SW, 5'd0, 5'd3, 16'h208));
        put(HALT);
        for (int d = 0; d < 2; d++) begin
            run_test((d == 0) ? "t1b" : "t1b_slow", d * 5, cyc);
            check("t1b_r1", mem[128], 32'd5);
            check("t1b_r2", mem[129], 32'hffff_fffe);
            check("t1b_r3", mem[130], 32'd1);
        end

        // lui/ori/sb/lb: byte lane 3 and sign extension
        clear_img();
        put(ei(OP_LUI, 5'd0, 5'd1, 16'h1234));
        put(ei(OP_ORI, 5'd1, 5'd1, 16'habcd));
        put(ei(OP_SB, 5'd0, 5'd1, 16'd3));
        put(ei(OP_LB, 5'd0, 5'd2, 16'd3));
        put(ei(OP_SW, 5'd0, 5'd2, 16'h200));
        put(HALT);
        run_test("t2", 0, cyc);
        check("t2_writes", wr_log.size(), 2);
        if (wr_log.size() > 0) begin
            check("t2_sb_we", wr_log[0][35:32], 4'b0001);
            check("t2_sb_byte", wr_log[0][7:0], 8'hcd);
        end
        check("t2_lb", mem[128], 32'hffff_ffcd);
        run_test("t2_slow", 5, cyc);

        // control flow: j, beq taken, jal, bne taken, jr
        clear_img();
        put(ei(OP_ADDI, 5'd0, 5'd6, 16'd1));
        put(ej(OP_J, 26'h8));
        pp = 32'h20;
        put(ei(OP_BEQ, 5'd0, 5'd0, 16'd2));
        put(ei(OP_ADDI, 5'd0, 5'd6, 16'd99));
        put(ei(OP_ADDI, 5'd0, 5'd6, 16'd98));
        put(ei(OP_ADDI, 5'd0, 5'd7, 16'd7));
        put(ej(OP_JAL, 26'h40));
        put(ei(OP_SW, 5'd0, 5'd31, 16'h200));
        put(ei(OP_SW, 5'd0, 5'd6, 16'h204));
        put(ei(OP_SW, 5'd0, 5'd7, 16'h208));
        put(HALT);
        pp = 32'h100;
        put(ei(OP_BNE, 5'd7, 5'd0, 16'd1));
        put(ei(OP_ADDI, 5'd0, 5'd7, 16'd0));
        put(er(5'd31, 5'd0, 5'd0, FN_JR));
        for (int d = 0; d < 2; d++) begin
            run_test((d == 0) ? "t3" : "t3_slow", d * 5, cyc);
            nxt = 32'hffff_ffff;
            for (int i = 0; i + 1 < rd_log.size(); i++)
                if (rd_log[i] == 32'h20) nxt = rd_log[i + 1];
            check("t3_after_beq", nxt, 32'h2c);
            check("t3_link", mem[128], 32'h34);
            check("t3_skip", mem[129], 32'd1);
            check("t3_bne", mem[130], 32'd7);
            check("t3_pc", pc, 32'h44);
        end

        // writes to $0 discarded; unknown opcode retires as a NOP
        clear_img();
        put(ei(OP_ADDI, 5'd0, 5'd0, 16'd9));
        put(er(5'd0, 5'd0, 5'd4, FN_ADD));
        put(ei(OP_SW, 5'd0, 5'd4, 16'h200));
        put(32'hfc00_0000);
        put(ei(OP_SW, 5'd0, 5'd0, 16'h204));
        put(HALT);
        img[128] = 32'hdead_beef;
        img[129] = 32'hcafe_f00d;
        run_test("t4", 0, cyc);
        check("t4_r4", mem[128], 32'h0);
        check("t4_r0", mem[129], 32'h0);
        check("t4_instret", instret, 5);
        check("t4_writes", n_writes, 2);

        for (int s = 0; s < 6; s++) begin
            gen_random();
            run_test($sformatf("rnd%0d", s), $urandom_range(5, 0), cyc);
        end

        // reset while a store is stalled in MEM
        clear_img();
        put(ei(OP_ADDI, 5'd0, 5'd1, 16'h55));
        put(ei(OP_SW, 5'd0, 5'd1, 16'h200));
        put(HALT);
        mem = img;
        sb_on = 0; stall_writes = 1; max_delay = 0; n_writes = 0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        k = 0;
        while (mem_we == 4'b0 && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("rst_sw_we", mem_we, 4'b1111);
        check("rst_sw_wdata", mem_wdata, 32'h55);
        check("rst_sw_addr", mem_addr, 32'h200);
        check("rst_pre_instret", instret, 1);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("rst_req_drop", mem_req, 0);
        check("rst_we_drop", mem_we, 0);
        check("rst_pc", pc, 32'h0);
        check("rst_instret", instret, 0);
        check("rst_finish", finish, 0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_no_write", n_writes, 0);
        check("rst_mem", mem[128], 32'h0);
        stall_writes = 0; sb_on = 1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
